// File: rtl/transform_loader.sv
// -----------------------------------------------------------------------------
// transform_loader
//
// Writer side of the transform table. It packs a byte stream of ASCII
// character pairs into 16-bit table words {lhs, rhs} and writes them to
// consecutive word addresses. At every end of line it also writes the line
// pointer {len[5:0], start[5:0]}, indexed by the line number.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_data/      byte stream input; in_last marks the final byte
//   in_last/in_ready       of a line
//   mem_we/mem_waddr/      one-cycle table word write
//   mem_din
//   ptr_we/ptr_line/       one-cycle line pointer write
//   ptr_data
//   line_count             lines committed so far
//   words_used             words written so far
//   full                   table exhausted (sticky until reset)
//   err                    a line was truncated (sticky until reset)
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready depends only on internal state (low once the table is full), never
// on in_valid. The source holds in_data/in_last stable while in_valid is high
// and in_ready is low.
// -----------------------------------------------------------------------------
module transform_loader #(
    parameter int          MAX_WORDS = 64,
    parameter int          MAX_LINES = 64,
    parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_waddr,
    output logic [15:0] mem_din,
    output logic        ptr_we,
    output logic [5:0]  ptr_line,
    output logic [11:0] ptr_data,
    output logic [6:0]  line_count,
    output logic [6:0]  words_used,
    output logic        full,
    output logic        err
);

    localparam logic [1:0] ST_HI   = 2'd0;  // awaiting lhs byte
    localparam logic [1:0] ST_LO   = 2'd1;  // awaiting rhs byte
    localparam logic [1:0] ST_DROP = 2'd2;  // discarding rest of an over-long line
    localparam logic [1:0] ST_FULL = 2'd3;  // table exhausted

    localparam logic [6:0] MAX_WORDS_W = 7'(MAX_WORDS);
    localparam logic [6:0] MAX_LINES_W = 7'(MAX_LINES);
    localparam logic [5:0] MAX_LINE_LEN = 6'd63;

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [7:0]  lhs_q;
    logic [6:0]  wptr;        // 7 bits so the "== MAX_WORDS" state is representable
    logic [6:0]  line_idx;
    logic [5:0]  line_start;
    logic [5:0]  line_wc;

    logic        accept;
    logic        emit;
    logic [15:0] word;
    logic [6:0]  wptr_nx;
    logic [5:0]  wc_nx;
    logic [6:0]  line_nx;
    logic        mem_full;
    logic        long_hit;
    logic        close;
    logic        trunc;
    logic        go_full;

    assign in_ready = (state != ST_FULL);

    always_comb begin
        accept   = in_valid && in_ready;
        // A word is produced by an rhs byte, or by an lhs byte that ends the line.
        emit     = accept && (((state == ST_HI) && in_last) || (state == ST_LO));
        word     = (state == ST_HI) ? {in_data, PAD_CHAR} : {lhs_q, in_data};
        wptr_nx  = wptr + 7'd1;
        wc_nx    = line_wc + 6'd1;
        line_nx  = line_idx + 7'd1;
        mem_full = (wptr_nx == MAX_WORDS_W);
        long_hit = (wc_nx == MAX_LINE_LEN);
        // A line closes on its last byte, when it hits the length limit, or
        // when the table runs out mid-line.
        close    = emit && (in_last || long_hit || mem_full);
        trunc    = close && !in_last;
        go_full  = emit && (mem_full || (close && (line_nx == MAX_LINES_W)));

        state_nx = state;
        if (accept) begin
            case (state)
                ST_HI:   state_nx = in_last ? ST_HI : ST_LO;
                ST_LO:   state_nx = ST_HI;
                ST_DROP: state_nx = in_last ? ST_HI : ST_DROP;
                default: state_nx = state;
            endcase
            if (trunc) begin
                state_nx = ST_DROP;
            end
            // Full takes priority so a pending lhs byte is never written.
            if (go_full) begin
                state_nx = ST_FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HI;
            lhs_q      <= 8'd0;
            wptr       <= 7'd0;
            line_idx   <= 7'd0;
            line_start <= 6'd0;
            line_wc    <= 6'd0;
            mem_we     <= 1'b0;
            mem_waddr  <= 8'd0;
            mem_din    <= 16'd0;
            ptr_we     <= 1'b0;
            ptr_line   <= 6'd0;
            ptr_data   <= 12'd0;
            line_count <= 7'd0;
            words_used <= 7'd0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            ptr_we <= 1'b0;
            state  <= state_nx;

            if (accept && (state == ST_HI) && !in_last) begin
                lhs_q <= in_data;
            end

            if (emit) begin
                mem_we     <= 1'b1;
                mem_waddr  <= {2'b00, wptr[5:0]};
                mem_din    <= word;
                wptr       <= wptr_nx;
                words_used <= wptr_nx;
                line_wc    <= wc_nx;
                if (close) begin
                    ptr_we     <= 1'b1;
                    ptr_line   <= line_idx[5:0];
                    ptr_data   <= {wc_nx, line_start};
                    line_idx   <= line_nx;
                    line_count <= line_nx;
                    line_start <= wptr_nx[5:0];
                    line_wc    <= 6'd0;
                end
                if (trunc) begin
                    err <= 1'b1;
                end
                if (go_full) begin
                    full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_transform_loader.sv
// -----------------------------------------------------------------------------
// tb_transform_loader
//
// Directed bench for transform_loader: a table of byte vectors with their
// hand-computed expected word/pointer writes, plus hand-written sequences for
// long lines, table exhaustion and reset in mid-line.
// -----------------------------------------------------------------------------
module tb_transform_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_din;
    logic        ptr_we;
    logic [5:0]  ptr_line;
    logic [11:0] ptr_data;
    logic [6:0]  line_count;
    logic [6:0]  words_used;
    logic        full;
    logic        err;

    transform_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_din    (mem_din),
        .ptr_we     (ptr_we),
        .ptr_line   (ptr_line),
        .ptr_data   (ptr_data),
        .line_count (line_count),
        .words_used (words_used),
        .full       (full),
        .err        (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  data;
        logic        last;
        int          gap;
        logic        has_w;
        logic [7:0]  waddr;
        logic [15:0] din;
        logic        has_p;
        logic [5:0]  pline;
        logic [11:0] pdata;
    } vec_t;

    logic [23:0] exp_q[$];   // {waddr, din}
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] data, input logic last, input int gap,
                                input logic has_w, input logic [7:0] waddr, input logic [15:0] din,
                                input logic has_p, input logic [5:0] pline, input logic [11:0] pdata);
        vec_t v;
        v.data = data;  v.last = last;   v.gap = gap;
        v.has_w = has_w; v.waddr = waddr; v.din = din;
        v.has_p = has_p; v.pline = pline; v.pdata = pdata;
        return v;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_waddr"},  32'(mem_waddr),  32'd0);
        check({tag, "_mem_din"},    32'(mem_din),    32'd0);
        check({tag, "_ptr_we"},     32'(ptr_we),     32'd0);
        check({tag, "_ptr_line"},   32'(ptr_line),   32'd0);
        check({tag, "_ptr_data"},   32'(ptr_data),   32'd0);
        check({tag, "_line_count"}, 32'(line_count), 32'd0);
        check({tag, "_words_used"}, 32'(words_used), 32'd0);
        check({tag, "_full"},       32'(full),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the accepting edge
    // with the registered outputs of that byte checked.
    task automatic send(input vec_t v);
        logic [23:0] e;
        for (int g = 0; g < v.gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("gap_mem_we", 32'(mem_we), 32'd0);
            check("gap_ptr_we", 32'(ptr_we), 32'd0);
        end
        check("in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_last  = v.last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (v.has_w) exp_q.push_back({v.waddr, v.din});
        check("mem_we", 32'(mem_we), 32'(v.has_w));
        if (mem_we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_waddr", 32'(mem_waddr), 32'(e[23:16]));
            check("mem_din",   32'(mem_din),   32'(e[15:0]));
        end
        check("ptr_we", 32'(ptr_we), 32'(v.has_p));
        if (v.has_p && ptr_we) begin
            check("ptr_line", 32'(ptr_line), 32'(v.pline));
            check("ptr_data", 32'(ptr_data), 32'(v.pdata));
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[12];

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;

        // Tests 1-4: pairs, padding, and in_valid gaps.
        tbl[0]  = mk(8'h31, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000);
        tbl[1]  = mk(8'h31, 1'b1, 0, 1'b1, 8'd0, 16'h3131, 1'b1, 6'd0, 12'h040);
        tbl[2]  = mk(8'h31, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000);
        tbl[3]  = mk(8'h74, 1'b0, 0, 1'b1, 8'd1, 16'h3174, 1'b0, 6'd0, 12'h000);
        tbl[4]  = mk(8'h73, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000);
        tbl[5]  = mk(8'h20, 1'b1, 0, 1'b1, 8'd2, 16'h7320, 1'b1, 6'd1, 12'h081);
        tbl[6]  = mk(8'h5E, 1'b1, 0, 1'b1, 8'd3, 16'h5E20, 1'b1, 6'd2, 12'h043);
        tbl[7]  = mk(8'h31, 1'b0, 2, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000);
        tbl[8]  = mk(8'h74, 1'b0, 3, 1'b1, 8'd4, 16'h3174, 1'b0, 6'd0, 12'h000);
        tbl[9]  = mk(8'h73, 1'b0, 1, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000);
        tbl[10] = mk(8'h20, 1'b1, 0, 1'b1, 8'd5, 16'h7320, 1'b1, 6'd3, 12'h084);
        tbl[11] = mk(8'h00, 1'b0, 2, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) send(tbl[i]);
        check("t4_line_count", 32'(line_count), 32'd4);
        check("t4_words_used", 32'(words_used), 32'd6);
        check("t4_err",        32'(err),        32'd0);
        check("t4_full",       32'(full),       32'd0);

        // Test 7: reset after an lhs byte, mid-line.
        send(mk(8'h41, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000));
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(mk(8'h42, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000));
        send(mk(8'h43, 1'b1, 0, 1'b1, 8'd0, 16'h4243, 1'b1, 6'd0, 12'h040));
        check("t7_line_count", 32'(line_count), 32'd1);

        // Test 5: 130-byte line truncated at 63 words, then a 1-word line
        // that lands on word 63 and exhausts the table in the same cycle.
        do_reset();
        for (int i = 0; i < 130; i++) begin
            b1 = 8'h41 + 8'(i % 26);
            if (i < 126 && (i % 2) == 1) begin
                send(mk(b1, 1'b0, 0, 1'b1, 8'(i / 2), {b0, b1},
                        (i == 125), 6'd0, 12'hFC0));
            end else begin
                send(mk(b1, (i == 129), 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000));
            end
            b0 = b1;
            if (i == 125) check("t5_err_at_trunc", 32'(err), 32'd1);
        end
        check("t5_words_used", 32'(words_used), 32'd63);
        check("t5_line_count", 32'(line_count), 32'd1);
        send(mk(8'h61, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000));
        send(mk(8'h62, 1'b1, 0, 1'b1, 8'd63, 16'h6162, 1'b1, 6'd1, 12'h07F));
        check("t5_full",       32'(full),       32'd1);
        check("t5_in_ready",   32'(in_ready),   32'd0);
        check("t5_err",        32'(err),        32'd1);
        check("t5_line_count", 32'(line_count), 32'd2);

        // Memory fills mid-line: 62-word line, then a line cut at word 64.
        do_reset();
        for (int i = 0; i < 124; i++) begin
            b1 = 8'h30 + 8'(i % 10);
            if ((i % 2) == 1) begin
                send(mk(b1, (i == 123), 0, 1'b1, 8'(i / 2), {b0, b1},
                        (i == 123), 6'd0, 12'hF80));
            end else begin
                send(mk(b1, 1'b0, 0, 1'b0, 8'd0, 16'h0000, 1'b0, 6'd0, 12'h000));
            end
            b0 = b1;
        end
        check("t8_err_before", 32'(err), 32'd0);
        send(mk(8'h70, 1'b0, 0, 1'b0, 8'd0,  16'h0000, 1'b0, 6'd0, 12'h000));
        send(mk(8'h71, 1'b0, 0, 1'b1, 8'd62, 16'h7071, 1'b0, 6'd0, 12'h000));
        send(mk(8'h72, 1'b0, 0, 1'b0, 8'd0,  16'h0000, 1'b0, 6'd0, 12'h000));
        send(mk(8'h73, 1'b0, 0, 1'b1, 8'd63, 16'h7273, 1'b1, 6'd1, 12'h0BE));
        check("t8_err",      32'(err),      32'd1);
        check("t8_full",     32'(full),     32'd1);
        check("t8_in_ready", 32'(in_ready), 32'd0);

        // Test 6: 64 one-word lines exhaust both word and line space.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            b1 = 8'h30 + 8'(i % 10);
            send(mk(b1, 1'b1, 0, 1'b1, 8'(i), {b1, 8'h20}, 1'b1, 6'(i), {6'd1, 6'(i)}));
            if (i == 62) check("t6_full_early", 32'(full), 32'd0);
        end
        check("t6_full",       32'(full),       32'd1);
        check("t6_in_ready",   32'(in_ready),   32'd0);
        check("t6_line_count", 32'(line_count), 32'd64);
        check("t6_words_used", 32'(words_used), 32'd64);
        check("t6_err",        32'(err),        32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_ignored_mem_we", 32'(mem_we), 32'd0);
            check("t6_ignored_ptr_we", 32'(ptr_we), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t6_words_after", 32'(words_used), 32'd64);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transform_loader.md
Name: transform_loader

Overview:
- Writer side of the transform table. Accepts a byte stream of ASCII character pairs and packs each pair into one 16-bit table word: lhs in bits [15:8], rhs in bits [7:0].
- Writes the packed words sequentially into the transform memory.
- At each end of line, writes a 12-bit line pointer {len[5:0], start[5:0]} into the line-pointer table, indexed by line number.
- Its output is exactly the word/pointer format the transform reader walks.

Parameters:
- MAX_WORDS, 64, number of table words available (≤64, because the start field is 6 bits).
- MAX_LINES, 64, number of pointer-table entries.
- PAD_CHAR, 8'h20, rhs fill byte when a line ends on an lhs byte.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte available
- in_data  in  8  ASCII byte
- in_last  in  1  byte is the final byte of the current line
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  table word write strobe
- mem_waddr  out  8  table word address
- mem_din  out  16  packed word {lhs, rhs}
- ptr_we  out  1  pointer write strobe
- ptr_line  out  6  pointer-table index
- ptr_data  out  12  {len[5:0], start[5:0]}
- line_count  out  7  lines committed
- words_used  out  7  words written
- full  out  1  table exhausted; sticky
- err  out  1  line truncated; sticky

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered except in_ready.
- Reset values: all outputs 0; internal state HI; word pointer 0; line index 0; line start 0; line word count 0.
- Accept condition: a byte is accepted on a rising edge when in_valid && in_ready. in_ready = (state != FULL). There is no other backpressure.
- State HI (awaiting lhs byte):
  - Accepted byte is latched as lhs.
  - in_last=0: go to LO.
  - in_last=1: emit word {lhs, PAD_CHAR}, close the line, stay in HI.
- State LO (awaiting rhs byte):
  - Accepted byte completes the word {lhs, byte}, which is emitted; go to HI.
  - in_last=1: also close the line.
- Word emit: in the cycle after the accepting edge, mem_we=1 for exactly one cycle, with mem_waddr = word pointer and mem_din = packed word. The word pointer and words_used then increment.
- Line close: in the same cycle as the final mem_we, ptr_we=1 for one cycle, with ptr_line = line index and ptr_data = {words in line, line start}. Then:
  - line index and line_count increment;
  - line start = new word pointer;
  - line word count resets to 0.
- Long line: if a line reaches 63 words without in_last, the line is closed at the 63rd word (len=63) and err is set. State DROP is entered: bytes keep being accepted and discarded up to and including the in_last byte, then return to HI.
- Full:
  - If after any emit the word pointer == MAX_WORDS or the line index == MAX_LINES, go to state FULL: full=1, in_ready=0 until reset.
  - If memory fills mid-line, the partial line is closed in the same cycle as its last mem_we (len = words written) and err is set.
  - A pending lhs byte in HI→LO is never written once FULL.
- Simultaneous events: a line close and a full condition on the same word produce both ptr_we and full, asserted together on the following edge.
- Reset mid-operation: a partially received word or line is discarded and never written. The table restarts at word 0, line 0.
- Width rules:
  - mem_waddr is zero-extended from the 6-bit word pointer.
  - len and start are truncated to 6 bits. This is safe, because len ≤ 63 and start < 64.

Test Plan:
1. Bytes 0x31, 0x31 (in_last on 2nd) → mem_we @addr 0, din=16'h3131; ptr_we line 0, ptr_data=12'h040; line_count=1.
2. Then 0x31,0x74,0x73,0x20 with in_last on byte 4 → words 0x3174 @1 and 0x7320 @2; ptr line 1, ptr_data={6'd2,6'd1}=12'h081.
3. Single byte 0x5E with in_last → din=16'h5E20 (padded); ptr len=1.
4. Same stream as 2, with in_valid gaps of 0–3 cycles between bytes → identical writes; no strobe lasts longer than one cycle.
5. 130 bytes with in_last on byte 130 → 63 words written; ptr len=63; err=1; bytes 127–130 dropped; the next line starts at word 63.
6. 64 one-word lines → full=1 after the 64th ptr_we; in_ready=0; line_count=64; words_used=64. Further in_valid is ignored.
7. Reset asserted after an lhs byte, mid-line → all outputs 0 immediately. The next two bytes with in_last write word 0, pointer line 0.
